// File: rtl/data_mem_sequencer.sv
// Load/store responder: turns one sized memory request into big-endian byte
// accesses on an 8-bit synchronous RAM, returning sign-extended load data.
module data_mem_sequencer #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        mem_read,
   input  logic [1:0]        mem_write,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [7:0]        ram_wdata,
   input  logic [7:0]        ram_rdata
);

   typedef enum logic [2:0] {IDLE, WR, RD, RDLAST, DONE} state_t;

   state_t              state, state_nxt;
   logic [1:0]          idx, idx_nxt;
   logic [1:0]          size_q;
   logic [1:0]          last_idx;
   logic [1:0]          code;
   logic [ADDR_W-1:0]   base;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         asm_q;
   logic [31:0]         asm_shift;
   logic [31:0]         wsh;
   logic [31:0]         load_ext;
   logic                err_q;
   logic                both;
   logic                misalign;
   logic                accept;
   logic                unused_bits;

   assign unused_bits = ^{addr[31:ADDR_W], asm_q[31:24]};

   // Size code 01/10/11 maps to final byte index 0/1/3.
   assign last_idx  = {size_q[1] & size_q[0], size_q[1]};
   assign asm_shift = {asm_q[23:0], ram_rdata};

   always_comb begin
      code     = (mem_read != 2'b00) ? mem_read : mem_write;
      both     = (mem_read != 2'b00) && (mem_write != 2'b00);
      misalign = ((code == 2'b10) && addr[0]) ||
                 ((code == 2'b11) && (addr[1:0] != 2'b00));
      accept   = req_valid && (state == IDLE) && (code != 2'b00);

      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (accept) begin
               idx_nxt = '0;
               if (both || misalign)          state_nxt = DONE;
               else if (mem_read != 2'b00)    state_nxt = RD;
               else                           state_nxt = WR;
            end
         end
         WR: begin
            if (idx == last_idx) state_nxt = DONE;
            else                 idx_nxt   = idx + 2'd1;
         end
         RD: begin
            if (idx == last_idx) state_nxt = RDLAST;
            else                 idx_nxt   = idx + 2'd1;
         end
         RDLAST:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      req_ready = (state == IDLE);
      busy      = (state != IDLE);
      rsp_valid = (state == DONE);
      rsp_err   = (state == DONE) && err_q;
      ram_we    = (state == WR);

      // Most significant byte of the datum first: shift by (n-1-idx) bytes.
      wsh       = wdata_q >> {last_idx - idx, 3'b000};
      ram_wdata = (state == WR) ? wsh[7:0] : '0;
      ram_addr  = ((state == WR) || (state == RD)) ? base + ADDR_W'(idx) : ram_addr_q;

      case (size_q)
         2'b01:   load_ext = {{24{asm_shift[7]}}, asm_shift[7:0]};
         2'b10:   load_ext = {{16{asm_shift[15]}}, asm_shift[15:0]};
         default: load_ext = asm_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         size_q     <= '0;
         base       <= '0;
         ram_addr_q <= '0;
         wdata_q    <= '0;
         asm_q      <= '0;
         err_q      <= 1'b0;
         rdata      <= '0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         ram_addr_q <= ram_addr;
         if (accept) begin
            base    <= addr[ADDR_W-1:0];
            size_q  <= code;
            wdata_q <= wdata;
            err_q   <= both || misalign;
         end
         // Read data lags the address by one cycle, so byte idx-1 arrives in RD idx.
         if (((state == RD) && (idx != 2'd0)) || (state == RDLAST))
            asm_q <= asm_shift;
         if (state == RDLAST)
            rdata <= load_ext;
      end
   end

endmodule

// File: tb/tb_data_mem_sequencer.sv
// Self-checking bench for data_mem_sequencer: directed cases plus randomized
// requests compared against a byte-array memory model.
module tb_data_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  mem_read = 2'b00;
   logic [1:0]  mem_write = 2'b00;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rdata;
   logic        busy;
   logic [9:0]  ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem     [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic        mem_loaded = 1'b0;
   int          we_cnt = 0;
   logic [31:0] model_rdata = '0;

   data_mem_sequencer #(.ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rdata(rdata), .busy(busy),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM the sequencer drives; preloaded on its first clock.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'((i * 37 + 5) & 255);
         mem_loaded <= 1'b1;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

   task automatic do_req(input logic [1:0] rd, input logic [1:0] wr,
                         input logic [31:0] a, input logic [31:0] wd, input string name);
      logic [1:0]  c;
      int          n, exp_lat, exp_we, lat, busy_low, we0;
      logic        exp_err;
      logic [31:0] val;
      int          b;
      c       = (rd != 2'b00) ? rd : wr;
      n       = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 4;
      exp_err = (rd != 2'b00 && wr != 2'b00) || (c == 2'b10 && a[0]) ||
                (c == 2'b11 && a[1:0] != 2'b00);
      exp_lat = exp_err ? 1 : (rd != 2'b00 ? n + 2 : n + 1);
      exp_we  = (!exp_err && rd == 2'b00) ? n : 0;
      b       = int'(a % 1024);
      if (!exp_err && rd != 2'b00) begin
         val = '0;
         for (int i = 0; i < n; i++) val = (val << 8) | 32'(ref_mem[(b + i) % 1024]);
         if (n == 1 && val >= 32'd128)   val = val + 32'hFFFF_FF00;
         if (n == 2 && val >= 32'd32768) val = val + 32'hFFFF_0000;
         model_rdata = val;
      end else if (!exp_err) begin
         for (int i = 0; i < n; i++) ref_mem[(b + i) % 1024] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
      end

      we0 = we_cnt;
      req_valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL %s ready: got %b want 1", name, req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0; mem_read = 2'b00; mem_write = 2'b00;
      lat = 1; busy_low = 0;
      forever begin
         if (busy !== 1'b1) busy_low++;
         if (rsp_valid === 1'b1 || lat >= 30) break;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != exp_lat || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      checks++;
      if (rsp_err !== exp_err) begin
         errors++; $display("FAIL %s rsp_err: got %b want %b", name, rsp_err, exp_err);
      end
      checks++;
      if (busy_low != 0) begin
         errors++; $display("FAIL %s busy: low for %0d cycles want 0", name, busy_low);
      end
      checks++;
      if (we_cnt - we0 != exp_we) begin
         errors++; $display("FAIL %s ram_we count: got %0d want %0d", name, we_cnt - we0, exp_we);
      end
      checks++;
      if (rdata !== model_rdata) begin
         errors++; $display("FAIL %s rdata: got %h want %h", name, rdata, model_rdata);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL %s rsp pulse: got %b one cycle later want 0", name, rsp_valid);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({req_ready, busy, rsp_valid, rsp_err, ram_we} !== 5'b10000 ||
          rdata !== '0 || ram_addr !== '0 || ram_wdata !== '0) begin
         errors++;
         $display("FAIL reset_state: ready=%b busy=%b rv=%b re=%b we=%b rdata=%h ra=%h rw=%h want 1,0,0,0,0,0,0,0",
                  req_ready, busy, rsp_valid, rsp_err, ram_we, rdata, ram_addr, ram_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      do_req(2'b00, 2'b11, 32'h8, 32'h1122_3344, "sw_8");
      checks++;
      if ({mem[8], mem[9], mem[10], mem[11]} !== 32'h1122_3344) begin
         errors++; $display("FAIL sw_8 ram: got %h%h%h%h want 11223344", mem[8], mem[9], mem[10], mem[11]);
      end
      do_req(2'b11, 2'b00, 32'h8, '0, "lw_8");
      do_req(2'b00, 2'b01, 32'h9, 32'h0000_00A2, "sb_9");
      do_req(2'b01, 2'b00, 32'h9, '0, "lb_9");
      do_req(2'b10, 2'b00, 32'hA, '0, "lh_a");
      do_req(2'b00, 2'b11, 32'hFFFF_F3FC, 32'hDEAD_BEEF, "sw_top");
      do_req(2'b11, 2'b00, 32'h0000_03FC, '0, "lw_top");
      do_req(2'b10, 2'b00, 32'h3FE, '0, "lh_top");
   endtask

   task automatic test_errors();
      do_req(2'b10, 2'b00, 32'h3, '0, "lh_misaligned");
      do_req(2'b11, 2'b01, 32'h10, 32'h55, "rd_and_wr");
      do_req(2'b00, 2'b11, 32'h12, 32'h0102_0304, "sw_misaligned");
   endtask

   task automatic test_no_code();
      int seen = 0;
      req_valid = 1'b1; mem_read = 2'b00; mem_write = 2'b00; addr = 32'h20;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
      end
      req_valid = 1'b0;
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL no_code: %0d cycles with response or not ready, want 0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int lat = 0;
      ref_mem[64] = 8'h85;
      req_valid = 1'b1; mem_write = 2'b01; mem_read = 2'b00; addr = 32'h40; wdata = 32'h85;
      @(negedge clk);
      req_valid = 1'b1; mem_write = 2'b00; mem_read = 2'b01;
      while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_first_rsp: ready=%b rsp=%b want 0,1", req_ready, rsp_valid);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_ready: got %b want 1", req_ready);
      end
      @(negedge clk);
      req_valid = 1'b0; mem_read = 2'b00;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL b2b_accept: busy got %b want 1", busy);
      end
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      model_rdata = 32'hFFFF_FF85;
      checks++;
      if (lat != 3 || rdata !== model_rdata) begin
         errors++; $display("FAIL b2b_lb: latency %0d rdata %h want 3 %h", lat, rdata, model_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [1:0]  rd, wr;
      logic [31:0] a;
      int          sel;
      for (int k = 0; k < 40; k++) begin
         sel = int'($urandom_range(0, 9));
         rd = 2'($urandom_range(1, 3));
         wr = 2'($urandom_range(1, 3));
         if (sel < 4)      wr = 2'b00;
         else if (sel < 8) rd = 2'b00;
         a = $urandom;
         if ($urandom_range(0, 9) < 7) a[1:0] = 2'b00;
         do_req(rd, wr, a, $urandom, "random");
      end
   endtask

   task automatic test_reset_mid();
      ref_mem[32] = 8'hAA; ref_mem[33] = 8'hBB;
      req_valid = 1'b1; mem_write = 2'b11; mem_read = 2'b00; addr = 32'h20; wdata = 32'hAABB_CCDD;
      @(negedge clk);
      req_valid = 1'b0; mem_write = 2'b00;
      repeat (2) @(negedge clk);
      checks++;
      if (ram_we !== 1'b1 || ram_addr !== 10'h22 || ram_wdata !== 8'hCC) begin
         errors++; $display("FAIL mid_third_byte: we=%b addr=%h data=%h want 1 022 cc", ram_we, ram_addr, ram_wdata);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ram_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_async: we=%b rsp=%b ready=%b want 0 0 1", ram_we, rsp_valid, req_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_rdata = '0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL mid_after_release: rsp=%b ready=%b want 0 1", rsp_valid, req_ready);
         end
      end
      checks++;
      if ({mem[32], mem[33], mem[34], mem[35]} !== {8'hAA, 8'hBB, ref_mem[34], ref_mem[35]}) begin
         errors++; $display("FAIL mid_ram: got %h%h%h%h want aabb%h%h", mem[32], mem[33], mem[34], mem[35],
                            ref_mem[34], ref_mem[35]);
      end
      do_req(2'b11, 2'b00, 32'h20, '0, "lw_after_reset");
   endtask

   task automatic test_final_ram();
      int bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL final_ram: %0d bytes differ from model, want 0", bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'((i * 37 + 5) & 255);
      test_reset();
      test_directed();
      test_errors();
      test_no_code();
      test_back_to_back();
      test_random();
      test_reset_mid();
      test_final_ram();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
